// File: rtl/digit_scanner.sv
// Scan controller for an 8-digit multiplexed display: steps through enabled digits,
// holding each for DIV cycles and blanking for BLANK_CYCLES cycles in between.
module digit_scanner #(
  parameter int DIV          = 50000,
  parameter int DIV_WIDTH    = 16,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iRun,
  input  logic [31:0] iValue,
  input  logic [7:0]  iDigitEn,
  output logic [2:0]  oSel,
  output logic [1:0]  oEna,
  output logic [3:0]  oNibble,
  output logic        oFrame
);

  localparam int GAP_WIDTH = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(DIV - 1);
  localparam logic [GAP_WIDTH-1:0] GAP_LAST   = GAP_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [1:0] ENA_DRIVE = 2'b10;
  localparam logic [1:0] ENA_BLANK = 2'b00;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [GAP_WIDTH-1:0] gap_q, gap_d;
  logic [2:0]           sel_q, sel_d;
  logic [1:0]           ena_q, ena_d;
  logic [3:0]           nibble_q, nibble_d;
  logic                 frame_q, frame_d;

  logic                 abort;
  logic [2:0]           next_idx;

  function automatic logic [2:0] lowest_enabled(input logic [7:0] en);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (en[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Falls back to the current index when no other digit is enabled (offset 8).
  function automatic logic [2:0] next_enabled(input logic [7:0] en, input logic [2:0] cur);
    logic [2:0] idx;
    logic [2:0] cand;
    idx = cur;
    for (int i = 7; i >= 1; i--) begin
      cand = cur + 3'(i);
      if (en[cand]) idx = cand;
    end
    return idx;
  endfunction

  assign abort    = !iRun || (iDigitEn == 8'h00);
  assign next_idx = next_enabled(iDigitEn, sel_q);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    gap_d    = gap_q;
    sel_d    = sel_q;
    ena_d    = ena_q;
    nibble_d = nibble_q;
    frame_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ena_d = ENA_BLANK;
        if (!abort) begin
          state_d  = SHOW;
          sel_d    = lowest_enabled(iDigitEn);
          nibble_d = iValue[{lowest_enabled(iDigitEn), 2'b00} +: 4];
          ena_d    = ENA_DRIVE;
          presc_d  = '0;
        end
      end
      SHOW: begin
        if (abort) begin
          state_d = IDLE;
          ena_d   = ENA_BLANK;
          presc_d = '0;
          gap_d   = '0;
        end else if (presc_q == PRESC_LAST) begin
          state_d = GAP;
          ena_d   = ENA_BLANK;
          presc_d = '0;
          gap_d   = '0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          ena_d   = ENA_BLANK;
          presc_d = '0;
          gap_d   = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d  = SHOW;
          sel_d    = next_idx;
          nibble_d = iValue[{next_idx, 2'b00} +: 4];
          ena_d    = ENA_DRIVE;
          frame_d  = (next_idx <= sel_q);
          gap_d    = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ena_d   = ENA_BLANK;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      gap_q    <= '0;
      sel_q    <= '0;
      ena_q    <= ENA_BLANK;
      nibble_q <= '0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      gap_q    <= gap_d;
      sel_q    <= sel_d;
      ena_q    <= ena_d;
      nibble_q <= nibble_d;
      frame_q  <= frame_d;
    end
  end

  assign oSel    = sel_q;
  assign oEna    = ena_q;
  assign oNibble = nibble_q;
  assign oFrame  = frame_q;

endmodule

// File: tb/tb_digit_scanner.sv
// Scoreboard bench for digit_scanner: every expected SHOW entry is queued by the
// stimulus process and checked by a monitor when the DUT starts driving a digit.
module tb_digit_scanner;

  logic        clk;
  logic        iRst_n;
  logic        iRun;
  logic [31:0] iValue;
  logic [7:0]  iDigitEn;
  logic [2:0]  oSel;
  logic [1:0]  oEna;
  logic [3:0]  oNibble;
  logic        oFrame;

  int tests;
  int failures;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] nib;
    logic       frame;
    int         at;
    int         dwell;
  } exp_t;

  exp_t sb[$];

  digit_scanner #(.DIV(3), .DIV_WIDTH(4), .BLANK_CYCLES(1)) dut (
    .iClk    (clk),
    .iRst_n  (iRst_n),
    .iRun    (iRun),
    .iValue  (iValue),
    .iDigitEn(iDigitEn),
    .oSel    (oSel),
    .oEna    (oEna),
    .oNibble (oNibble),
    .oFrame  (oFrame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input int s, input int n, input int f, input int at, input int dw);
    exp_t e;
    e.sel   = 3'(s);
    e.nib   = 4'(n);
    e.frame = f[0];
    e.at    = at;
    e.dwell = dw;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic run, input logic [7:0] en, input logic [31:0] value);
    iRun     = run;
    iDigitEn = en;
    iValue   = value;
  endtask

  // Waits for the blanking cycle that follows the last queued SHOW entry.
  task automatic waitGap(input int maxCycles);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < maxCycles; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && oEna == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL waitGap timeout: got no gap after %0d cycles, expected gap", maxCycles);
    end
  endtask

  task automatic waitSel(input logic [2:0] s, input int maxCycles);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < maxCycles; n++) begin
      @(negedge clk);
      if (oSel == s && oEna == 2'b10) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL waitSel timeout: got no SHOW of digit %0d, expected one", s);
    end
  endtask

  // Monitor: tracks SHOW runs, checks each entry against the scoreboard.
  initial begin : monitor
    exp_t cur;
    bit   inShow;
    bit   spurious;
    int   showLen;
    int   cycle;
    int   base;
    inShow   = 1'b0;
    spurious = 1'b0;
    showLen  = 0;
    cycle    = 0;
    base     = 0;
    cur.sel = '0; cur.nib = '0; cur.frame = 1'b0; cur.at = 0; cur.dwell = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (oEna === 2'b10) begin
        if (!inShow) begin
          inShow   = 1'b1;
          showLen  = 1;
          spurious = 1'b0;
          tests++;
          if (sb.size() == 0) begin
            failures++;
            $display("[TB] FAIL unexpected SHOW entry: got oSel=%0d, expected none", oSel);
            cur.sel = oSel; cur.nib = oNibble; cur.frame = 1'b0; cur.at = 0; cur.dwell = -1;
          end else begin
            cur = sb.pop_front();
            if (cur.at == 0) base = cycle;
            else checkOutput("entry cycle", 32'(cycle - base), 32'(cur.at));
            checkOutput("entry oSel", 32'(oSel), 32'(cur.sel));
            checkOutput("entry oNibble", 32'(oNibble), 32'(cur.nib));
            checkOutput("entry oFrame", 32'(oFrame), 32'(cur.frame));
          end
        end else begin
          showLen++;
          checkOutput("hold oSel", 32'(oSel), 32'(cur.sel));
          checkOutput("hold oNibble", 32'(oNibble), 32'(cur.nib));
          if (oFrame !== 1'b0) spurious = 1'b1;
        end
      end else begin
        if (inShow) begin
          inShow = 1'b0;
          checkOutput("dwell length", 32'(showLen), 32'(cur.dwell));
          checkOutput("frame only on entry", 32'(spurious), 32'(0));
        end else if (oFrame !== 1'b0) begin
          checkOutput("oFrame while blank", 32'(oFrame), 32'(0));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin : stimulus
    tests    = 0;
    failures = 0;
    iRst_n   = 1'b0;
    applyStimulus(1'b0, 8'h00, 32'h0);

    // Reset state and release
    repeat (2) @(negedge clk);
    checkOutput("reset oSel", 32'(oSel), 32'(0));
    checkOutput("reset oEna", 32'(oEna), 32'(0));
    checkOutput("reset oNibble", 32'(oNibble), 32'(0));
    checkOutput("reset oFrame", 32'(oFrame), 32'(0));
    iRst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle after release oEna", 32'(oEna), 32'(0));

    // Full scan 0..7 then wrap to 0 with a frame pulse at cycle 32
    for (int k = 0; k < 8; k++) pushExp(k, k, 0, 4 * k, 3);
    pushExp(0, 0, 1, 32, 3);
    applyStimulus(1'b1, 8'hFF, 32'h76543210);
    waitGap(100);
    applyStimulus(1'b0, 8'hFF, 32'h76543210);
    @(negedge clk);
    checkOutput("abort from gap oEna", 32'(oEna), 32'(0));

    // Sparse scan 2,5,2,5,2
    pushExp(2, 2, 0, 0, 3);
    pushExp(5, 5, 0, 4, 3);
    pushExp(2, 2, 1, 8, 3);
    pushExp(5, 5, 0, 12, 3);
    pushExp(2, 2, 1, 16, 3);
    applyStimulus(1'b1, 8'b0010_0100, 32'h76543210);
    waitGap(100);
    applyStimulus(1'b0, 8'b0010_0100, 32'h76543210);
    @(negedge clk);

    // Abort on the second SHOW cycle of digit 3, then restart
    pushExp(0, 0, 0, 0, 3);
    pushExp(1, 1, 0, 4, 3);
    pushExp(2, 2, 0, 8, 3);
    pushExp(3, 3, 0, 12, 2);
    applyStimulus(1'b1, 8'hFF, 32'h76543210);
    waitSel(3'd3, 100);
    @(negedge clk);
    applyStimulus(1'b0, 8'hFF, 32'h76543210);
    @(negedge clk);
    checkOutput("abort oEna", 32'(oEna), 32'(0));
    checkOutput("abort holds oSel", 32'(oSel), 32'(3));
    repeat (2) @(negedge clk);
    checkOutput("idle after abort oEna", 32'(oEna), 32'(0));
    pushExp(0, 0, 0, 0, 3);
    applyStimulus(1'b1, 8'hFF, 32'h76543210);
    @(negedge clk);
    checkOutput("restart oEna", 32'(oEna), 32'(2));
    checkOutput("restart oSel", 32'(oSel), 32'(0));
    waitGap(100);
    applyStimulus(1'b0, 8'hFF, 32'h76543210);
    @(negedge clk);

    // No digits enabled, then clear the enables mid-gap
    applyStimulus(1'b1, 8'h00, 32'h76543210);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("no digits oEna", 32'(oEna), 32'(0));
    end
    pushExp(0, 0, 0, 0, 3);
    pushExp(1, 1, 0, 4, 3);
    applyStimulus(1'b1, 8'hFF, 32'h76543210);
    waitGap(100);
    applyStimulus(1'b1, 8'h00, 32'h76543210);
    @(negedge clk);
    checkOutput("cleared mid gap oEna", 32'(oEna), 32'(0));
    @(negedge clk);
    checkOutput("cleared stays idle oEna", 32'(oEna), 32'(0));
    applyStimulus(1'b0, 8'h00, 32'h76543210);
    @(negedge clk);

    // Single digit 7 with a value change during the first dwell
    pushExp(7, 7, 0, 0, 3);
    pushExp(7, 10, 1, 4, 3);
    pushExp(7, 10, 1, 8, 3);
    applyStimulus(1'b1, 8'h80, 32'h76543210);
    @(negedge clk);
    @(negedge clk);
    iValue = 32'hA6543210;
    waitGap(100);
    applyStimulus(1'b0, 8'h80, 32'hA6543210);
    @(negedge clk);

    // Asynchronous reset in the middle of digit 4's dwell
    pushExp(4, 4, 0, 0, 2);
    applyStimulus(1'b1, 8'h10, 32'h76543210);
    @(negedge clk);
    @(negedge clk);
    #2 iRst_n = 1'b0;
    #1;
    checkOutput("async reset oSel", 32'(oSel), 32'(0));
    checkOutput("async reset oEna", 32'(oEna), 32'(0));
    checkOutput("async reset oNibble", 32'(oNibble), 32'(0));
    checkOutput("async reset oFrame", 32'(oFrame), 32'(0));
    repeat (3) begin
      @(negedge clk);
      checkOutput("held in reset oEna", 32'(oEna), 32'(0));
    end
    pushExp(4, 4, 0, 0, 3);
    iRst_n = 1'b1;
    @(negedge clk);
    checkOutput("first edge after reset oEna", 32'(oEna), 32'(2));
    waitGap(100);
    applyStimulus(1'b0, 8'h10, 32'h76543210);
    repeat (2) @(negedge clk);

    checkOutput("scoreboard drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
